// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver with a small byte FIFO behind a
// shared 8-bit I/O bus.
//
// Ports
//   clk         system clock, all state updates on its rising edge
//   reset       synchronous active-high reset
//   io_bus      shared tri-state bus; driven only on a selected read (rnw=1)
//   sel_data    data register select (read pops the FIFO head)
//   sel_status  status register select; read = {3'b0,ferr,perr,ovf,full,not_empty}
//               and clears ovf/perr/ferr, write flushes FIFO and all flags
//   rnw         1 = device drives bus, 0 = bus drives device
//   ps2_clk     keyboard clock, asynchronous, idle high
//   ps2_data    keyboard data, asynchronous, idle high
//   irq         high while the FIFO holds at least one byte
module ps2_keyboard #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 2000
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] io_bus,
  input  logic       sel_data,
  input  logic       sel_status,
  input  logic       rnw,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // [1:0] synchronize ps2_clk, [2] holds the previous synchronized value
  logic [2:0] kclk_sh;
  logic [1:0] kdat_sh;
  logic       fall, kdat;

  always_ff @(posedge clk) begin
    if (reset) begin
      kclk_sh <= 3'b111;
      kdat_sh <= 2'b11;
    end else begin
      kclk_sh <= {kclk_sh[1:0], ps2_clk};
      kdat_sh <= {kdat_sh[0], ps2_data};
    end
  end

  assign fall = kclk_sh[2] & ~kclk_sh[1];
  assign kdat = kdat_sh[1];

  // frame FSM
  state_t        state, state_nx;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          shift_en, bit_clr, par_ld;
  logic          push_req, set_perr, set_ferr;

  // to_cnt counts clk cycles since the last falling edge while a frame is open
  assign timeout_hit = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    bit_clr  = 1'b0;
    par_ld   = 1'b0;
    push_req = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    if (timeout_hit) begin
      state_nx = IDLE;
    end else if (fall) begin
      case (state)
        IDLE: if (!kdat) begin
          state_nx = DATA;
          bit_clr  = 1'b1;
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
        PARITY: begin
          par_ld   = 1'b1;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          // bad stop bit dominates: the parity bit of a misframed byte is meaningless
          if (!kdat)                    set_ferr = 1'b1;
          else if (^{shreg, par_bit})   push_req = 1'b1;
          else                          set_perr = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg   <= {kdat, shreg[7:1]};   // LSB arrives first
      if (par_ld)   par_bit <= kdat;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TW'(1);
    end
  end

  // receive FIFO
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          not_empty, full;
  logic          rd_data, rd_stat, wr_stat, pop, push, ovf_set;
  logic          ovf, perr, ferr;

  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign rd_stat   = sel_status & rnw;
  assign wr_stat   = sel_status & ~rnw;
  assign rd_data   = sel_data & rnw & ~sel_status;   // status wins when both selected
  assign pop       = rd_data & not_empty;
  // a simultaneous pop frees the slot, so a push onto a full FIFO still lands
  assign push      = push_req & (~full | pop);
  assign ovf_set   = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push && !wr_stat) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset || wr_stat) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // sticky flags: a read clears, but a set landing on the same edge survives
  always_ff @(posedge clk) begin
    if (reset || wr_stat) begin
      ovf  <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovf  <= (ovf  & ~rd_stat) | ovf_set;
      perr <= (perr & ~rd_stat) | set_perr;
      ferr <= (ferr & ~rd_stat) | set_ferr;
    end
  end

  // bus interface
  logic [7:0] status, bus_out;
  logic       bus_en;

  assign status  = {3'b000, ferr, perr, ovf, full, not_empty};
  assign bus_out = sel_status ? status : (not_empty ? mem[rd_ptr] : 8'h00);
  assign bus_en  = rnw & (sel_data | sel_status);
  assign io_bus  = bus_en ? bus_out : {8{1'bz}};
  assign irq     = not_empty;

endmodule
